// File: rtl/alu_32bit_seq_if.sv
// Handshake and data bundle for the registered 32-bit ALU stage.
// master: upstream controller plus downstream consumer side (drives requests, accepts results).
// slave:  the ALU stage itself.
interface alu_32bit_seq_if;
    logic        valid_in;
    logic        ready_out;
    logic [2:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic        valid_out;
    logic        ready_in;
    logic [31:0] z;
    logic        zero;
    logic        ovf;

    modport master (
        output valid_in, op, x, y, ready_in,
        input  ready_out, valid_out, z, zero, ovf
    );

    modport slave (
        input  valid_in, op, x, y, ready_in,
        output ready_out, valid_out, z, zero, ovf
    );
endinterface

// File: rtl/alu_32bit_seq.sv
// Registered, handshaked 32-bit ALU stage: AND, OR, ADD, SUB, NOR, signed SLT.
// Optional feature macro ALU_SLTU_EN: when defined, OP 3'b101 computes unsigned
// set-less-than; when undefined it behaves as an unused opcode (Z=0, ZERO=1, OVF=0).
//
// state | meaning
// IDLE  | ready_out=1, waiting for valid_in; captures op/x/y on handshake
// EXEC  | operands held internally, result registered on the next edge
// HOLD  | valid_out=1, result stable until ready_in is seen at an edge
module alu_32bit_seq (
    input  logic               clk,
    input  logic               rst,
    alu_32bit_seq_if.slave     bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b111;
    localparam logic [2:0] OP_SLTU = 3'b101;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  op_q;
    logic [31:0] x_q;
    logic [31:0] y_q;
    logic [31:0] z_q;
    logic        zero_q;
    logic        ovf_q;

    logic [31:0] sum;
    logic [31:0] diff;
    logic [31:0] res;
    logic        res_ovf;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; handshake outputs are pure state decodes.
    always_comb begin
        state_nxt     = state;
        bus.ready_out = 1'b0;
        bus.valid_out = 1'b0;
        case (state)
            IDLE: begin
                bus.ready_out = 1'b1;
                if (bus.valid_in) state_nxt = EXEC;
            end
            EXEC: state_nxt = HOLD;
            HOLD: begin
                bus.valid_out = 1'b1;
                if (bus.ready_in) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture; later changes on the bus cannot disturb an op in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= 3'b000;
            x_q  <= 32'd0;
            y_q  <= 32'd0;
        end else if (state == IDLE && bus.valid_in) begin
            op_q <= bus.op;
            x_q  <= bus.x;
            y_q  <= bus.y;
        end
    end

    assign sum  = x_q + y_q;
    assign diff = x_q - y_q;

    // Result and overflow evaluation from the captured operands.
    // SLT uses a true signed compare rather than the sign of diff, so it stays
    // correct when x-y overflows.
    always_comb begin
        res     = 32'd0;
        res_ovf = 1'b0;
        case (op_q)
            OP_AND: res = x_q & y_q;
            OP_OR:  res = x_q | y_q;
            OP_NOR: res = ~(x_q | y_q);
            OP_ADD: begin
                res     = sum;
                res_ovf = (x_q[31] == y_q[31]) && (sum[31] != x_q[31]);
            end
            OP_SUB: begin
                res     = diff;
                res_ovf = (x_q[31] != y_q[31]) && (diff[31] != x_q[31]);
            end
            OP_SLT: res = {31'd0, ($signed(x_q) < $signed(y_q))};
`ifdef ALU_SLTU_EN
            OP_SLTU: res = {31'd0, (x_q < y_q)};
`endif
            default: begin
                res     = 32'd0;
                res_ovf = 1'b0;
            end
        endcase
    end

    // Result register, loaded only on the EXEC->HOLD edge so it is stable in HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            z_q    <= 32'd0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (state == EXEC) begin
            z_q    <= res;
            zero_q <= (res == 32'd0);
            ovf_q  <= res_ovf;
        end
    end

    assign bus.z    = z_q;
    assign bus.zero = zero_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_alu_32bit_seq.sv
// Scoreboard bench for alu_32bit_seq: stimulus pushes expected results, a
// negedge monitor pops and compares on every valid_out/ready_in handshake.
module tb_alu_32bit_seq;
    typedef struct packed {
        logic [31:0] z;
        logic        zero;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];

    alu_32bit_seq_if bus();

    alu_32bit_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    endtask

    // Monitor: one comparison set per completed output handshake.
    always @(negedge clk) begin
        if (!rst && bus.valid_out && bus.ready_in) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: got z=0x%08h with empty scoreboard", bus.z);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("z", bus.z, e.z);
                chk("zero", {31'd0, bus.zero}, {31'd0, e.zero});
                chk("ovf", {31'd0, bus.ovf}, {31'd0, e.ovf});
            end
        end
    end

    // Issue one request; leaves the stage in HOLD. Checks latency on the way.
    task automatic send(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input logic [31:0] ez, input logic eovf);
        int t;
        exp_t e;
        if (push) begin
            e.z = ez; e.zero = (ez == 32'd0); e.ovf = eovf;
            exp_q.push_back(e);
        end
        t = 0;
        while (!bus.ready_out && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (t == 50) begin
            n_checks++;
            $display("FAIL ready_timeout: got ready_out=0 expected 1 within 50 cycles");
        end
        bus.op = o; bus.x = a; bus.y = b; bus.valid_in = 1'b1;
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        bus.op = 3'($urandom); bus.x = $urandom; bus.y = $urandom;
        chk("exec_valid_out", {31'd0, bus.valid_out}, 32'd0);
        chk("exec_ready_out", {31'd0, bus.ready_out}, 32'd0);
        @(posedge clk); #1;
        chk("hold_valid_out", {31'd0, bus.valid_out}, 32'd1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (bus.valid_out && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (t == 50) begin
            n_checks++;
            $display("FAIL drain_timeout: got valid_out=1 expected 0 within 50 cycles");
        end
    endtask

    task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ez, input logic eovf);
        send(o, a, b, 1'b1, ez, eovf);
        drain();
    endtask

    logic [31:0] z_held;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.valid_in = 1'b0; bus.op = 3'b000; bus.x = 32'd0; bus.y = 32'd0; bus.ready_in = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready_out", {31'd0, bus.ready_out}, 32'd1);
        chk("rst_valid_out", {31'd0, bus.valid_out}, 32'd0);
        chk("rst_z", bus.z, 32'd0);
        chk("rst_zero", {31'd0, bus.zero}, 32'd0);
        chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);
        rst = 1'b0;

        // SLT, including overflow-prone compares
        run(3'b111, 32'h8429842f, 32'h22feabc3, 32'd1, 1'b0);
        run(3'b111, 32'h22feabc3, 32'h8429842f, 32'd0, 1'b0);
        run(3'b111, 32'h7fffffff, 32'hffffffff, 32'd0, 1'b0);
        run(3'b111, 32'hffffffff, 32'h70ffffff, 32'd1, 1'b0);
        run(3'b111, 32'hffffffff, 32'hffffffff, 32'd0, 1'b0);
        // arithmetic
        run(3'b010, 32'h7fffffff, 32'h00000001, 32'h80000000, 1'b1);
        run(3'b110, 32'h80000000, 32'h00000001, 32'h7fffffff, 1'b1);
        run(3'b110, 32'd5, 32'd5, 32'd0, 1'b0);
        run(3'b010, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 1'b0);
        run(3'b010, 32'h80000000, 32'h80000000, 32'd0, 1'b1);
        run(3'b110, 32'h00000003, 32'h00000007, 32'hfffffffc, 1'b0);
        // logic ops and unused opcode
        run(3'b000, 32'hf0f0a5a5, 32'h0ff0ffff, 32'h00f0a5a5, 1'b0);
        run(3'b001, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0);
        run(3'b100, 32'h00000000, 32'h00000000, 32'hffffffff, 1'b0);
        run(3'b100, 32'hffffffff, 32'h00000000, 32'h00000000, 1'b0);
        run(3'b011, 32'h12345678, 32'h11111111, 32'h00000000, 1'b0);
`ifdef ALU_SLTU_EN
        run(3'b101, 32'h00000000, 32'hffffffff, 32'd1, 1'b0);
`else
        run(3'b101, 32'h00000000, 32'hffffffff, 32'd0, 1'b0);
`endif

        // backpressure: hold for 5 cycles while inputs wiggle
        bus.ready_in = 1'b0;
        send(3'b010, 32'h00001000, 32'h00000234, 1'b1, 32'h00001234, 1'b0);
        z_held = bus.z;
        chk("bp_z_loaded", z_held, 32'h00001234);
        for (int i = 0; i < 5; i++) begin
            bus.valid_in = i[0];
            bus.x = $urandom; bus.y = $urandom; bus.op = 3'($urandom);
            @(posedge clk); #1;
            chk("bp_z_stable", bus.z, z_held);
            chk("bp_ready_out", {31'd0, bus.ready_out}, 32'd0);
            chk("bp_valid_out", {31'd0, bus.valid_out}, 32'd1);
        end
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_idle", {31'd0, bus.ready_out}, 32'd1);
        chk("bp_release_valid", {31'd0, bus.valid_out}, 32'd0);

        // reset during EXEC
        bus.ready_in = 1'b0;
        bus.op = 3'b010; bus.x = 32'd7; bus.y = 32'd9; bus.valid_in = 1'b1;
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        chk("exec_state", {31'd0, bus.ready_out}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_exec_valid_out", {31'd0, bus.valid_out}, 32'd0);
        chk("rst_exec_z", bus.z, 32'd0);
        chk("rst_exec_ready_out", {31'd0, bus.ready_out}, 32'd1);

        // reset during HOLD
        send(3'b001, 32'h0000ff00, 32'h000000ff, 1'b0, 32'd0, 1'b0);
        chk("hold_z_before_rst", bus.z, 32'h0000ffff);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_hold_valid_out", {31'd0, bus.valid_out}, 32'd0);
        chk("rst_hold_z", bus.z, 32'd0);
        chk("rst_hold_ready_out", {31'd0, bus.ready_out}, 32'd1);
        bus.ready_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // stage still works after aborts
        run(3'b010, 32'd40, 32'd2, 32'd42, 1'b0);
        repeat (2) @(posedge clk);

        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_empty: got %0d pending expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
